unidad_carga_almacen: RTL and testbench

Load/store initiator that sits between the MIPS MEM stage and the word-addressed data memory (256 × 32-bit words, combinational read, write while `Wen`=1). It accepts one byte/halfword/word load or store per request and drives `Wen`, `Ren`, `Adress` and `DataW` into the memory. It captures `DataR` and returns extracted, sign- or zero-extended load data. The memory has no byte enables, so sub-word stores use an internal read-modify-write sequence.

---
 rtl/unidad_carga_almacen.sv | 104 ++++++++++
 tb/tb_unidad_carga_almacen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/unidad_carga_almacen.sv
// unidad_carga_almacen: byte/half/word load-store initiator with read-modify-write for sub-word stores
module unidad_carga_almacen #(
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        escribir,
    input  logic [1:0]  tam,
    input  logic        sin_signo,
    input  logic [31:0] dir,
    input  logic [31:0] dato_in,
    output logic        listo,
    output logic        valido,
    output logic [31:0] dato_out,
    output logic        error_alin,
    output logic        error_rango,
    output logic        Wen,
    output logic        Ren,
    output logic [31:0] Adress,
    output logic [31:0] DataW,
    input  logic [31:0] DataR
);
    typedef enum logic [1:0] {REPOSO, LEER, ESCRIBIR, FIN} estado_t;
    estado_t estado, sig;
    logic        esc_r, sin_r;
    logic [1:0]  tam_r, lane_r;
    logic [15:0] dato_r;
    logic        acepta, mal_alin, fuera;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] fusion, carga;

    assign listo    = estado == REPOSO;
    assign acepta   = req && listo;
    assign mal_alin = (tam == 2'b01 && dir[0]) || (tam[1] && dir[1:0] != 2'b00);
    assign fuera    = |dir[31:AW+2];

    // next state: errors skip memory, word stores skip the read, sub-word stores read first
    always_comb begin
        sig = estado;
        case (estado)
            REPOSO:   if (acepta) sig = (mal_alin || fuera) ? FIN : (escribir && tam[1]) ? ESCRIBIR : LEER;
            LEER:     sig = esc_r ? ESCRIBIR : FIN;
            ESCRIBIR: sig = FIN;
            default:  sig = REPOSO;
        endcase
    end

    // lane extraction for loads and lane merge for sub-word stores, both from the word just read
    always_comb begin
        b      = DataR[{lane_r, 3'b000} +: 8];
        h      = DataR[{lane_r[1], 4'b0000} +: 16];
        carga  = tam_r == 2'b00 ? {{24{~sin_r & b[7]}}, b} :
                 tam_r == 2'b01 ? {{16{~sin_r & h[15]}}, h} : DataR;
        fusion = DataR;
        if (tam_r == 2'b00)
            fusion[{lane_r, 3'b000} +: 8] = dato_r[7:0];
        else
            fusion[{lane_r[1], 4'b0000} +: 16] = dato_r;
    end

    // state, request capture and registered memory/handshake outputs; strobes follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= REPOSO;
            esc_r       <= 1'b0;
            sin_r       <= 1'b0;
            tam_r       <= 2'b00;
            lane_r      <= 2'b00;
            dato_r      <= '0;
            valido      <= 1'b0;
            Wen         <= 1'b0;
            Ren         <= 1'b0;
            error_alin  <= 1'b0;
            error_rango <= 1'b0;
            dato_out    <= '0;
            Adress      <= '0;
            DataW       <= '0;
        end else begin
            estado <= sig;
            Wen    <= sig == ESCRIBIR;
            Ren    <= sig == LEER;
            valido <= sig == FIN;
            if (acepta) begin
                esc_r       <= escribir;
                sin_r       <= sin_signo;
                tam_r       <= tam;
                lane_r      <= dir[1:0];
                dato_r      <= dato_in[15:0];
                Adress      <= {{(32-AW){1'b0}}, dir[AW+1:2]};
                DataW       <= dato_in;
                error_alin  <= mal_alin;
                error_rango <= fuera;
            end
            if (estado == LEER) begin
                if (esc_r)
                    DataW <= fusion;
                else
                    dato_out <= carga;
            end
        end
    end
endmodule

// File: tb/tb_unidad_carga_almacen.sv
// tb_unidad_carga_almacen: scoreboard bench with a behavioural 256-word data memory
module tb_unidad_carga_almacen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        escribir = 1'b0;
    logic [1:0]  tam = 2'b00;
    logic        sin_signo = 1'b0;
    logic [31:0] dir = '0;
    logic [31:0] dato_in = '0;
    logic        listo, valido, error_alin, error_rango, Wen, Ren;
    logic [31:0] dato_out, Adress, DataW, DataR;

    typedef struct {
        logic [31:0] dato;
        logic        alin;
        logic        rango;
        int          ciclo;
    } esperado_t;

    esperado_t   q[$];
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [31:0] ult = '0;
    int          ciclo = 0;
    int          total = 0;
    int          aciertos = 0;
    int          n_wen = 0;
    int          n_ren = 0;
    int          choques = 0;

    unidad_carga_almacen #(.AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .escribir(escribir), .tam(tam),
        .sin_signo(sin_signo), .dir(dir), .dato_in(dato_in), .listo(listo),
        .valido(valido), .dato_out(dato_out), .error_alin(error_alin),
        .error_rango(error_rango), .Wen(Wen), .Ren(Ren), .Adress(Adress),
        .DataW(DataW), .DataR(DataR)
    );

    always #5 clk = ~clk;

    assign DataR = mem[Adress[7:0]];

    always @(posedge clk) begin
        ciclo <= ciclo + 1;
        if (Wen) mem[Adress[7:0]] <= DataW;
    end

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) aciertos++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (Wen) n_wen++;
        if (Ren) n_ren++;
        if (Wen && Ren) choques++;
        if (valido && rst_n) begin
            if (q.size() == 0) comprobar("valido_extra", 32'd1, 32'd0);
            else begin
                esperado_t e;
                e = q.pop_front();
                comprobar("dato_out", dato_out, e.dato);
                comprobar("error_alin", {31'd0, error_alin}, {31'd0, e.alin});
                comprobar("error_rango", {31'd0, error_rango}, {31'd0, e.rango});
                comprobar("latencia", ciclo, e.ciclo);
            end
        end
    end

    task automatic enviar(input logic e, input logic [1:0] t, input logic s,
                          input logic [31:0] d, input logic [31:0] din);
        int n = 0;
        esperado_t x;
        logic [31:0] w, v, m;
        int sh;
        @(negedge clk);
        req = 1'b1; escribir = e; tam = t; sin_signo = s; dir = d; dato_in = din;
        while (!listo && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!listo) comprobar("listo_timeout", 32'd0, 32'd1);
        x.alin  = (t == 2'b01 && d[0]) || (t >= 2'b10 && d[1:0] != 2'b00);
        x.rango = d[31:10] != 22'd0;
        w = ref_mem[d[9:2]];
        if (x.alin || x.rango) x.ciclo = ciclo + 1;
        else if (!e || t >= 2'b10) x.ciclo = ciclo + 2;
        else x.ciclo = ciclo + 3;
        if (!(x.alin || x.rango)) begin
            if (!e) begin
                if (t == 2'b00) begin
                    v = (w >> (8 * d[1:0])) & 32'hFF;
                    if (!s && v[7]) v = v | 32'hFFFFFF00;
                end else if (t == 2'b01) begin
                    v = (w >> (16 * d[1])) & 32'hFFFF;
                    if (!s && v[15]) v = v | 32'hFFFF0000;
                end else v = w;
                ult = v;
            end else begin
                if (t == 2'b00) begin
                    sh = 8 * d[1:0];
                    m = 32'hFF << sh;
                    w = (w & ~m) | ((din & 32'hFF) << sh);
                end else if (t == 2'b01) begin
                    sh = 16 * d[1];
                    m = 32'hFFFF << sh;
                    w = (w & ~m) | ((din & 32'hFFFF) << sh);
                end else w = din;
                ref_mem[d[9:2]] = w;
            end
        end
        x.dato = ult;
        q.push_back(x);
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic esperar();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            comprobar("fin_timeout", q.size(), 32'd0);
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int acc;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        mem[1] = 32'd20;          ref_mem[1] = 32'd20;
        mem[2] = 32'd45;          ref_mem[2] = 32'd45;
        mem[8] = 32'h11223344;    ref_mem[8] = 32'h11223344;
        mem[16] = 32'h0000007B;   ref_mem[16] = 32'h0000007B;
        repeat (3) @(negedge clk);
        comprobar("reset_listo", {31'd0, listo}, 32'd1);
        comprobar("reset_flags", {27'd0, valido, Wen, Ren, error_alin, error_rango}, 32'd0);
        comprobar("reset_dato_out", dato_out, 32'd0);
        comprobar("reset_adress", Adress, 32'd0);
        comprobar("reset_dataw", DataW, 32'd0);
        rst_n = 1'b1;

        enviar(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        comprobar("lw_ren", {30'd0, Ren, Wen}, 32'd2);
        comprobar("lw_adress", Adress, 32'd1);
        esperar();

        enviar(1'b1, 2'b00, 1'b0, 32'h41, 32'hFF);
        comprobar("sb_leer", {30'd0, Ren, Wen}, 32'd2);
        @(posedge clk); #1;
        comprobar("sb_escribir", {30'd0, Ren, Wen}, 32'd1);
        comprobar("sb_dataw", DataW, 32'h0000FF7B);
        comprobar("sb_adress", Adress, 32'd16);
        esperar();
        comprobar("mem16", mem[16], 32'h0000FF7B);

        enviar(1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
        enviar(1'b0, 2'b01, 1'b0, 32'h40, 32'h0);
        enviar(1'b0, 2'b00, 1'b1, 32'h41, 32'h0);
        enviar(1'b0, 2'b00, 1'b0, 32'h41, 32'h0);
        esperar();

        acc = n_wen + n_ren;
        enviar(1'b1, 2'b01, 1'b0, 32'h43, 32'h1234);
        esperar();
        comprobar("sh_alin_sin_acceso", n_wen + n_ren - acc, 32'd0);
        acc = n_wen + n_ren;
        enviar(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        esperar();
        comprobar("lw_rango_sin_acceso", n_wen + n_ren - acc, 32'd0);
        enviar(1'b0, 2'b01, 1'b0, 32'h41, 32'h0);
        enviar(1'b0, 2'b10, 1'b0, 32'h42, 32'h0);
        esperar();

        enviar(1'b1, 2'b00, 1'b0, 32'h21, 32'h5A);
        enviar(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
        enviar(1'b1, 2'b10, 1'b0, 32'h0C, 32'hDEADBEEF);
        enviar(1'b1, 2'b01, 1'b0, 32'h42, 32'h00008001);
        enviar(1'b0, 2'b11, 1'b0, 32'h0C, 32'h0);
        enviar(1'b0, 2'b01, 1'b0, 32'h42, 32'h0);
        enviar(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        esperar();
        comprobar("mem8", mem[8], 32'h11225A44);
        comprobar("mem16_sh", mem[16], 32'h8001FF7B);

        acc = n_wen;
        @(negedge clk);
        req = 1'b1; escribir = 1'b1; tam = 2'b00; sin_signo = 1'b0; dir = 32'h06; dato_in = 32'h77;
        @(posedge clk);
        #1 req = 1'b0;
        comprobar("rst_en_leer", {30'd0, Ren, Wen}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        comprobar("rst_async_strobes", {30'd0, Ren, Wen}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ult = '0;
        @(negedge clk);
        comprobar("rst_sin_escritura", n_wen - acc, 32'd0);
        comprobar("rst_mem1", mem[1], 32'd20);
        comprobar("rst_listo", {31'd0, listo}, 32'd1);
        comprobar("rst_flags", {27'd0, valido, Wen, Ren, error_alin, error_rango}, 32'd0);
        comprobar("rst_dato_out", dato_out, 32'd0);
        comprobar("rst_adress_dataw", Adress | DataW, 32'd0);

        comprobar("wen_ren_juntos", choques, 32'd0);
        $display("%0d/%0d checks passed", aciertos, total);
        $finish;
    end
endmodule
